// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the Fibonacci generator and checker.
package lfsr_pkg;

  localparam int MAX_W = 64;

  localparam logic [15:0] TAPS_16 = 16'hB400;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  // Right shift with the tap parity entering bit width-1.
  function automatic logic [MAX_W-1:0] lfsr_fib_next(
    input logic [MAX_W-1:0] word,
    input logic [MAX_W-1:0] taps,
    input int unsigned      width
  );
    logic             fb;
    logic [MAX_W-1:0] r;
    fb = ^(word & taps);
    r  = (word >> 1) | (MAX_W'(fb) << (width - 1));
    return r;
  endfunction

endpackage

// File: rtl/lfsr_fibonacci_checker.sv
// Receive-side PRBS checker: self-syncs to a Fibonacci LFSR stream,
// then compares against a free-running local reference.
module lfsr_fibonacci_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = TAPS_16,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 4,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_V = LW'(LOSS_CNT);

  lfsr_state_e      state_q, state_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0] nxt_prev;
  logic [WIDTH-1:0] nxt_exp;
  logic [WIDTH-1:0] nxt_in;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;
  logic             hit;

  always_comb begin
    nxt_prev = WIDTH'(lfsr_fib_next(MAX_W'(prev_q), MAX_W'(TAPS), WIDTH));
    nxt_exp  = WIDTH'(lfsr_fib_next(MAX_W'(exp_q), MAX_W'(TAPS), WIDTH));
    nxt_in   = WIDTH'(lfsr_fib_next(MAX_W'(in_data), MAX_W'(TAPS), WIDTH));
    match_inc = match_cnt_q + MW'(1);
    miss_inc  = miss_cnt_q + LW'(1);
    hit = have_prev_q && (in_data == nxt_prev) && (in_data != '0);

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    exp_d       = exp_q;
    err_pulse_d = 1'b0;
    err_count_d = clear ? '0 : err_count_q;

    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          prev_d      = in_data;
          have_prev_d = 1'b1;
          if (!hit) begin
            match_cnt_d = '0;
          end else if (match_inc == LOCK_V) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            exp_d       = nxt_in;
            miss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_inc;
          end
        end
        LOCKED: begin
          // Reference never reseeds, so one bad word costs one error.
          exp_d = nxt_exp;
          if (in_data != exp_q) begin
            err_pulse_d = 1'b1;
            if (!clear && !(&err_count_q))
              err_count_d = err_count_q + CNT_W'(1);
            if (miss_inc == LOSS_V) begin
              state_d     = SEARCH;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
              prev_d      = in_data;
              have_prev_d = 1'b1;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= SEARCH;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      exp_q       <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      exp_q       <= exp_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
